// File: rtl/box_painter.sv
// box_painter: streams every pixel of a BOX_W x BOX_H rectangle into the VGA
// adapter's pixel-write port after a single start request.
// Pixels are sent one per accepted beat in row-major order, starting at the top-left pixel.
// Pixels outside SCREEN_W x SCREEN_H are skipped in one cycle without waiting on px_ready.
// Build option: define BOX_PAINTER_BORDER_EN to paint the outline in BORDER_COLOR.
// An erase (colour 0) always produces a solid fill.

module box_painter #(
    parameter int unsigned BOX_W        = 64,
    parameter int unsigned BOX_H        = 24,
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter logic [8:0]  BORDER_COLOR = 9'b000_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] x0,
    input  logic [8:0] y0,
    input  logic [8:0] color,
    input  logic       px_ready,
    output logic       plot,
    output logic [9:0] px_x,
    output logic [8:0] px_y,
    output logic [8:0] px_color,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CxW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int unsigned CyW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

    localparam logic [CxW-1:0] CxLast = CxW'(BOX_W - 1);
    localparam logic [CyW-1:0] CyLast = CyW'(BOX_H - 1);

    // Limits are one bit wider than the coordinates.
    // A limit beyond the coordinate range therefore never clips.
    localparam logic [10:0] XLim = 11'((SCREEN_W > 2047) ? 2047 : SCREEN_W);
    localparam logic [9:0]  YLim = 10'((SCREEN_H > 1023) ? 1023 : SCREEN_H);

    typedef enum logic [1:0] {
        StIdle,
        StDraw,
        StFinish
    } state_e;

    state_e         state_q, state_d;
    logic [9:0]     x0_q, x0_d;
    logic [8:0]     y0_q, y0_d;
    logic [8:0]     color_q, color_d;
    logic [CxW-1:0] cx_q, cx_d;
    logic [CyW-1:0] cy_q, cy_d;

    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic       clipped;
    logic       last_col;
    logic       last_row;
    logic       beat_done;
    logic       border_hit;

    // Current pixel address, clip test and beat completion
    always_comb begin
        pix_x     = x0_q + 10'(cx_q);
        pix_y     = y0_q + 9'(cy_q);
        clipped   = ({1'b0, pix_x} >= XLim) || ({1'b0, pix_y} >= YLim);
        last_col  = (cx_q == CxLast);
        last_row  = (cy_q == CyLast);
        // A clipped pixel completes its beat without waiting on the adapter.
        beat_done = (state_q == StDraw) && (clipped || px_ready);
    end

    // Outline detection; constant 0 unless the border build is selected
    always_comb begin
        border_hit = 1'b0;
`ifdef BOX_PAINTER_BORDER_EN
        border_hit = (color_q != 9'd0) &&
                     ((cx_q == '0) || last_col || (cy_q == '0) || last_row);
`else
        border_hit = 1'b0;
`endif
    end

    // FSM state register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDraw;
                end
            end
            StDraw: begin
                if (beat_done && last_col && last_row) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs; the pixel bus reads zero outside DRAW
    always_comb begin
        plot     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        px_x     = 10'd0;
        px_y     = 9'd0;
        px_color = 9'd0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
            end
            StDraw: begin
                busy     = 1'b1;
                plot     = ~clipped;
                px_x     = pix_x;
                px_y     = pix_y;
                px_color = border_hit ? BORDER_COLOR : color_q;
            end
            StFinish: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Request latch and column/row counters
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            x0_q    <= 10'd0;
            y0_q    <= 9'd0;
            color_q <= 9'd0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            color_q <= color_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

    // Latch the request in IDLE.
    // Otherwise, step the scan on each completed beat.
    always_comb begin
        x0_d    = x0_q;
        y0_d    = y0_q;
        color_d = color_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        if ((state_q == StIdle) && start) begin
            x0_d    = x0;
            y0_d    = y0;
            color_d = color;
            cx_d    = '0;
            cy_d    = '0;
        end else if (beat_done) begin
            if (last_col) begin
                cx_d = '0;
                // The final beat leaves both counters at zero for the next box.
                cy_d = last_row ? '0 : (cy_q + CyW'(1));
            end else begin
                cx_d = cx_q + CxW'(1);
            end
        end
    end

endmodule
